// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges MEM-stage load/store requests to a word-wide data
// memory. Sub-word loads are aligned and extended; sub-word stores run a
// read-modify-write. Misaligned or out-of-range accesses fault without
// touching memory.
// Optional build macro: MEM_ACCESS_STATS_EN (load/store completion counters).
module mem_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Req,
    input  logic [2:0]            in_Op,
    input  logic [DATA_WIDTH-1:0] in_Address_dw,
    input  logic [DATA_WIDTH-1:0] in_StoreData_dw,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Fault,
    output logic [DATA_WIDTH-1:0] o_LoadData_dw,
    output logic [DATA_WIDTH-1:0] o_MemAddress_dw,
    output logic [DATA_WIDTH-1:0] o_MemWriteData_dw,
    output logic                  o_MemWrite,
    output logic                  o_MemRead,
    input  logic [DATA_WIDTH-1:0] in_MemReadData_dw,
    output logic [15:0]           o_LoadCount,
    output logic [15:0]           o_StoreCount
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [DATA_WIDTH-1:0] LP_DEPTH = DATA_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_op;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_sdata;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_load_data;
    logic                  r_fault;
    logic                  w_fault;
    logic                  w_is_load;
    logic [DATA_WIDTH-1:0] w_word_idx;

    // Alignment rule: words need addr[1:0]==0, halfwords need addr[0]==0.
    function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] lsb);
        case (op)
            OP_LW, OP_SW:         return (lsb != 2'b00);
            OP_LH, OP_LHU, OP_SH: return lsb[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Little-endian lane extraction followed by sign or zero extension.
    function automatic logic [DATA_WIDTH-1:0] f_load_extract(input logic [2:0] op,
                                                             input logic [1:0] lsb,
                                                             input logic [DATA_WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lsb, 3'b000} +: 8];
        h = word[{lsb[1], 4'b0000} +: 16];
        case (op)
            OP_LH:   return {{(DATA_WIDTH-16){h[15]}}, h};
            OP_LHU:  return {{(DATA_WIDTH-16){1'b0}}, h};
            OP_LB:   return {{(DATA_WIDTH-8){b[7]}}, b};
            OP_LBU:  return {{(DATA_WIDTH-8){1'b0}}, b};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte or halfword lane of the fetched word.
    function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [2:0] op,
                                                      input logic [1:0] lsb,
                                                      input logic [DATA_WIDTH-1:0] word,
                                                      input logic [DATA_WIDTH-1:0] sd);
        logic [DATA_WIDTH-1:0] m;
        m = word;
        if (op == OP_SB) begin
            m[{lsb, 3'b000} +: 8] = sd[7:0];
        end else begin
            m[{lsb[1], 4'b0000} +: 16] = sd[15:0];
        end
        return m;
    endfunction

    assign w_word_idx      = {2'b00, in_Address_dw[DATA_WIDTH-1:2]};
    assign w_fault         = f_misaligned(in_Op, in_Address_dw[1:0]) || (w_word_idx >= LP_DEPTH);
    assign w_is_load       = (r_op <= OP_LBU);
    assign o_MemAddress_dw = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign o_LoadData_dw   = r_load_data;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch, fault flag, merge word and load result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= '0;
            r_addr      <= '0;
            r_sdata     <= '0;
            r_fault     <= 1'b0;
            r_merge     <= '0;
            r_load_data <= '0;
        end else begin
            if (r_state == S_IDLE && in_Req) begin
                r_op    <= in_Op;
                r_addr  <= in_Address_dw;
                r_sdata <= in_StoreData_dw;
                r_fault <= w_fault;
            end
            if (r_state == S_ACCESS) begin
                if (w_is_load) begin
                    r_load_data <= f_load_extract(r_op, r_addr[1:0], in_MemReadData_dw);
                end else if (r_op != OP_SW) begin
                    r_merge <= in_MemReadData_dw;
                end
            end
        end
    end

    // Next-state and memory/handshake outputs decoded from the current state.
    always_comb begin
        w_next_state      = r_state;
        o_Busy            = 1'b1;
        o_Done            = 1'b0;
        o_Fault           = 1'b0;
        o_MemRead         = 1'b0;
        o_MemWrite        = 1'b0;
        o_MemWriteData_dw = '0;
        case (r_state)
            S_IDLE: begin
                o_Busy = 1'b0;
                if (in_Req) begin
                    w_next_state = w_fault ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_is_load) begin
                    o_MemRead    = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_op == OP_SW) begin
                    o_MemWrite        = 1'b1;
                    o_MemWriteData_dw = r_sdata;
                    w_next_state      = S_DONE;
                end else begin
                    o_MemRead    = 1'b1;
                    w_next_state = S_MERGE;
                end
            end
            S_MERGE: begin
                o_MemWrite        = 1'b1;
                o_MemWriteData_dw = f_merge(r_op, r_addr[1:0], r_merge, r_sdata);
                w_next_state      = S_DONE;
            end
            S_DONE: begin
                o_Done       = 1'b1;
                o_Fault      = r_fault;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] r_load_cnt;
    logic [15:0] r_store_cnt;

    // Saturating counts of completed, non-faulted loads and stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
        end else if (r_state == S_DONE && !r_fault) begin
            if (w_is_load) begin
                if (r_load_cnt != 16'hFFFF) r_load_cnt <= r_load_cnt + 16'd1;
            end else begin
                if (r_store_cnt != 16'hFFFF) r_store_cnt <= r_store_cnt + 16'd1;
            end
        end
    end

    assign o_LoadCount  = r_load_cnt;
    assign o_StoreCount = r_store_cnt;
`else
    assign o_LoadCount  = 16'h0000;
    assign o_StoreCount = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: word memory environment plus a byte-level
// reference model of memory contents, load results, faults and latency.
module tb_mem_access_unit;

    localparam int DEPTH = 256;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_Req = 1'b0;
    logic [2:0]  in_Op = '0;
    logic [31:0] in_Address_dw = '0;
    logic [31:0] in_StoreData_dw = '0;
    logic        o_Busy, o_Done, o_Fault, o_MemWrite, o_MemRead;
    logic [31:0] o_LoadData_dw, o_MemAddress_dw, o_MemWriteData_dw, in_MemReadData_dw;
    logic [15:0] o_LoadCount, o_StoreCount;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_errors = 0;
    int mdl_ld = 0;
    int mdl_st = 0;
    logic [31:0] exp_hold = '0;

    logic [31:0] res_ld, res_wdata;
    logic        res_flt;
    int          res_lat, res_nrd, res_nwr, res_rd_k, res_wr_k;
    bit          res_busy_low;

    mem_access_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_Req(in_Req), .in_Op(in_Op),
        .in_Address_dw(in_Address_dw), .in_StoreData_dw(in_StoreData_dw),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Fault(o_Fault),
        .o_LoadData_dw(o_LoadData_dw), .o_MemAddress_dw(o_MemAddress_dw),
        .o_MemWriteData_dw(o_MemWriteData_dw), .o_MemWrite(o_MemWrite),
        .o_MemRead(o_MemRead), .in_MemReadData_dw(in_MemReadData_dw),
        .o_LoadCount(o_LoadCount), .o_StoreCount(o_StoreCount)
    );

    always #5 clk = ~clk;

    assign in_MemReadData_dw = mem[o_MemAddress_dw[9:2]];

    always @(posedge clk) begin
        if (o_MemWrite) mem[o_MemAddress_dw[9:2]] <= o_MemWriteData_dw;
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] op);
        case (op)
            LW, SW:      return 4;
            LH, LHU, SH: return 2;
            default:     return 1;
        endcase
    endfunction

    function automatic bit model_fault(input logic [2:0] op, input logic [31:0] addr);
        return ((addr % size_of(op)) != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] addr);
        if (model_fault(op, addr)) return 1;
        if (op == SH || op == SB) return 3;
        return 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
        longint v;
        int sh;
        sh = 8 * int'(addr % 4);
        v = longint'(ref_mem[addr / 4] >> sh) & ((64'd1 << (8 * size_of(op))) - 1);
        if (op == LB && v >= 128) v = v - 256;
        if (op == LH && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef MEM_ACCESS_STATS_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c < 0) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    task automatic model_commit(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
        longint unsigned m, o, d, n;
        int sh;
        if (model_fault(op, addr)) return;
        if (op <= LBU) begin
            exp_hold = model_load(op, addr);
            mdl_ld++;
        end else begin
            sh = 8 * int'(addr % 4);
            m = ((64'd1 << (8 * size_of(op))) - 1) << sh;
            o = 64'(ref_mem[addr / 4]);
            d = 64'(sd);
            n = (o & ~m) | ((d << sh) & m);
            ref_mem[addr / 4] = n[31:0];
            mdl_st++;
        end
    endtask

    task automatic model_reset();
        mdl_ld = 0;
        mdl_st = 0;
        exp_hold = '0;
    endtask

    // Issue one request from IDLE and observe until o_Done (bounded).
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd);
        @(negedge clk);
        in_Req = 1'b1; in_Op = op; in_Address_dw = addr; in_StoreData_dw = sd;
        @(posedge clk);
        res_lat = -1; res_nrd = 0; res_nwr = 0; res_rd_k = 0; res_wr_k = 0;
        res_busy_low = 0; res_flt = 1'bx; res_ld = 'x; res_wdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) in_Req = 1'b0;
            if (!o_Busy) res_busy_low = 1;
            if (o_MemRead) begin res_nrd++; if (res_rd_k == 0) res_rd_k = k; end
            if (o_MemWrite) begin res_nwr++; res_wdata = o_MemWriteData_dw; if (res_wr_k == 0) res_wr_k = k; end
            if (o_Done) begin res_lat = k; res_flt = o_Fault; res_ld = o_LoadData_dw; break; end
        end
        in_Req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (o_Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", o_Busy); end
        n_checks++; if (o_Done !== 1'b0 || o_Fault !== 1'b0) begin n_errors++; $display("FAIL reset_done_fault got=%0b%0b exp=00", o_Done, o_Fault); end
        n_checks++; if (o_MemRead !== 1'b0 || o_MemWrite !== 1'b0) begin n_errors++; $display("FAIL reset_enables got=%0b%0b exp=00", o_MemRead, o_MemWrite); end
        n_checks++; if (o_LoadData_dw !== 32'h0 || o_MemAddress_dw !== 32'h0 || o_MemWriteData_dw !== 32'h0) begin
            n_errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", o_LoadData_dw, o_MemAddress_dw, o_MemWriteData_dw); end
        n_checks++; if (o_LoadCount !== 16'h0 || o_StoreCount !== 16'h0) begin n_errors++; $display("FAIL reset_counts got=%h/%h exp=0", o_LoadCount, o_StoreCount); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [5] = '{LB, LBU, LH, LHU, LW};
        logic [31:0] adrs [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        @(negedge clk);
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
        for (int i = 0; i < 5; i++) begin
            run_access(ops[i], adrs[i], 32'h0);
            n_checks++; if (res_lat !== 2) begin n_errors++; $display("FAIL load%0d_latency got=%0d exp=2", i, res_lat); end
            n_checks++; if (res_flt !== 1'b0) begin n_errors++; $display("FAIL load%0d_fault got=%0b exp=0", i, res_flt); end
            n_checks++; if (res_ld !== exps[i]) begin n_errors++; $display("FAIL load%0d_data got=%h exp=%h", i, res_ld, exps[i]); end
            n_checks++; if (res_nrd !== 1 || res_nwr !== 0 || res_busy_low) begin
                n_errors++; $display("FAIL load%0d_bus got rd=%0d wr=%0d busylow=%0d exp 1/0/0", i, res_nrd, res_nwr, res_busy_low); end
            model_commit(ops[i], adrs[i], 32'h0);
        end
    endtask

    task automatic test_sub_store();
        run_access(SB, 32'h13, 32'h12345677);
        n_checks++; if (res_rd_k !== 1 || res_wr_k !== 2) begin n_errors++; $display("FAIL sb_timing got rd@%0d wr@%0d exp rd@1 wr@2", res_rd_k, res_wr_k); end
        n_checks++; if (res_wdata !== 32'h7799AABB) begin n_errors++; $display("FAIL sb_wdata got=%h exp=7799aabb", res_wdata); end
        n_checks++; if (res_lat !== 3 || res_flt !== 1'b0 || res_nwr !== 1) begin
            n_errors++; $display("FAIL sb_done got lat=%0d flt=%0b wr=%0d exp 3/0/1", res_lat, res_flt, res_nwr); end
        model_commit(SB, 32'h13, 32'h12345677);
        run_access(LW, 32'h10, 32'h0);
        n_checks++; if (res_ld !== 32'h7799AABB) begin n_errors++; $display("FAIL sb_readback got=%h exp=7799aabb", res_ld); end
        model_commit(LW, 32'h10, 32'h0);
        run_access(SH, 32'h12, 32'hCAFEBEEF);
        n_checks++; if (res_wdata !== 32'hBEEFAABB || res_lat !== 3) begin
            n_errors++; $display("FAIL sh_wdata got=%h lat=%0d exp=beefaabb lat=3", res_wdata, res_lat); end
        model_commit(SH, 32'h12, 32'hCAFEBEEF);
        n_checks++; if (mem[4] !== ref_mem[4]) begin n_errors++; $display("FAIL sh_memory got=%h exp=%h", mem[4], ref_mem[4]); end
    endtask

    task automatic test_faults();
        logic [2:0]  ops  [3] = '{SW, LH, LW};
        logic [31:0] adrs [3] = '{32'h02, 32'h01, 32'h400};
        for (int i = 0; i < 3; i++) begin
            run_access(ops[i], adrs[i], 32'hDEADBEEF);
            n_checks++; if (res_lat !== 1 || res_flt !== 1'b1) begin
                n_errors++; $display("FAIL fault%0d_done got lat=%0d flt=%0b exp 1/1", i, res_lat, res_flt); end
            n_checks++; if (res_nrd !== 0 || res_nwr !== 0) begin
                n_errors++; $display("FAIL fault%0d_bus got rd=%0d wr=%0d exp 0/0", i, res_nrd, res_nwr); end
            n_checks++; if (res_ld !== exp_hold) begin n_errors++; $display("FAIL fault%0d_hold got=%h exp=%h", i, res_ld, exp_hold); end
            model_commit(ops[i], adrs[i], 32'hDEADBEEF);
        end
        n_checks++; if (mem[0] !== ref_mem[0]) begin n_errors++; $display("FAIL fault_memory got=%h exp=%h", mem[0], ref_mem[0]); end
    endtask

    task automatic test_busy_ignore();
        int nrd = 0, nwr = 0, ndone = 0, done_k = 0;
        logic [31:0] exp_ld;
        exp_ld = model_load(LW, 32'h40);
        @(negedge clk);
        in_Req = 1'b1; in_Op = LW; in_Address_dw = 32'h40; in_StoreData_dw = 32'h0;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin in_Req = 1'b1; in_Op = SW; in_Address_dw = 32'h44; in_StoreData_dw = ~ref_mem[17]; end
            if (k == 2) in_Req = 1'b0;
            if (o_MemRead) nrd++;
            if (o_MemWrite) nwr++;
            if (o_Done) begin ndone++; if (done_k == 0) done_k = k; if (k == 2) res_ld = o_LoadData_dw; end
        end
        n_checks++; if (nwr !== 0 || nrd !== 1) begin n_errors++; $display("FAIL busy_ignore_bus got rd=%0d wr=%0d exp 1/0", nrd, nwr); end
        n_checks++; if (ndone !== 1 || done_k !== 2) begin n_errors++; $display("FAIL busy_ignore_done got n=%0d at=%0d exp 1 at 2", ndone, done_k); end
        n_checks++; if (res_ld !== exp_ld) begin n_errors++; $display("FAIL busy_ignore_data got=%h exp=%h", res_ld, exp_ld); end
        n_checks++; if (mem[17] !== ref_mem[17]) begin n_errors++; $display("FAIL busy_ignore_mem got=%h exp=%h", mem[17], ref_mem[17]); end
        model_commit(LW, 32'h40, 32'h0);
    endtask

    task automatic test_stats();
        logic [2:0]  ops  [6] = '{LW, SW, LB, SB, LHU, LW};
        logic [31:0] adrs [6] = '{32'h20, 32'h24, 32'h21, 32'h25, 32'h22, 32'h401};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_access(ops[i], adrs[i], $urandom);
            model_commit(ops[i], adrs[i], in_StoreData_dw);
        end
        @(negedge clk);
        n_checks++; if (o_LoadCount !== exp_cnt(3) || mdl_ld != 3) begin
            n_errors++; $display("FAIL stats_loads got=%0d exp=%0d", o_LoadCount, exp_cnt(3)); end
        n_checks++; if (o_StoreCount !== exp_cnt(2) || mdl_st != 2) begin
            n_errors++; $display("FAIL stats_stores got=%0d exp=%0d", o_StoreCount, exp_cnt(2)); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] addr, sd, exp_ld;
        int r, mism;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            sd = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) addr = 32'h400 + $urandom_range(0, 4095);
            else if (r == 1) addr = $urandom;
            else addr = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) addr = addr & ~(size_of(op) - 1);
            exp_ld = (!model_fault(op, addr) && op <= LBU) ? model_load(op, addr) : exp_hold;
            run_access(op, addr, sd);
            n_checks++; if (res_flt !== model_fault(op, addr)) begin
                n_errors++; $display("FAIL rand%0d_fault op=%0d a=%h got=%0b exp=%0b", i, op, addr, res_flt, model_fault(op, addr)); end
            n_checks++; if (res_lat !== model_latency(op, addr) || res_busy_low) begin
                n_errors++; $display("FAIL rand%0d_latency op=%0d a=%h got=%0d exp=%0d", i, op, addr, res_lat, model_latency(op, addr)); end
            n_checks++; if (res_ld !== exp_ld) begin
                n_errors++; $display("FAIL rand%0d_loaddata op=%0d a=%h got=%h exp=%h", i, op, addr, res_ld, exp_ld); end
            n_checks++;
            if (model_fault(op, addr) ? (res_nrd !== 0 || res_nwr !== 0) :
                (op <= LBU) ? (res_nrd !== 1 || res_nwr !== 0) :
                (op == SW) ? (res_nrd !== 0 || res_nwr !== 1) : (res_nrd !== 1 || res_nwr !== 1)) begin
                n_errors++; $display("FAIL rand%0d_bus op=%0d a=%h got rd=%0d wr=%0d", i, op, addr, res_nrd, res_nwr); end
            model_commit(op, addr, sd);
        end
        @(negedge clk);
        mism = 0;
        for (int w = 0; w < DEPTH; w++) if (mem[w] !== ref_mem[w]) mism++;
        n_checks++; if (mism != 0) begin n_errors++; $display("FAIL rand_memory got=%0d bad words exp=0", mism); end
        n_checks++; if (o_LoadCount !== exp_cnt(mdl_ld) || o_StoreCount !== exp_cnt(mdl_st)) begin
            n_errors++; $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", o_LoadCount, o_StoreCount, exp_cnt(mdl_ld), exp_cnt(mdl_st)); end
    endtask

    task automatic test_reset_in_merge();
        @(negedge clk);
        in_Req = 1'b1; in_Op = SB; in_Address_dw = 32'h31; in_StoreData_dw = ~ref_mem[12];
        @(posedge clk);
        @(negedge clk);
        in_Req = 1'b0;
        n_checks++; if (o_MemRead !== 1'b1) begin n_errors++; $display("FAIL rim_read got=%0b exp=1", o_MemRead); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (o_MemWrite !== 1'b0 || o_Busy !== 1'b0 || o_Done !== 1'b0) begin
            n_errors++; $display("FAIL rim_ctrl got wr=%0b busy=%0b done=%0b exp 000", o_MemWrite, o_Busy, o_Done); end
        n_checks++; if (o_LoadData_dw !== 32'h0 || o_MemAddress_dw !== 32'h0 || o_MemWriteData_dw !== 32'h0) begin
            n_errors++; $display("FAIL rim_data got=%h/%h/%h exp=0", o_LoadData_dw, o_MemAddress_dw, o_MemWriteData_dw); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_checks++; if (mem[12] !== ref_mem[12]) begin n_errors++; $display("FAIL rim_memory got=%h exp=%h", mem[12], ref_mem[12]); end
        n_checks++; if (o_LoadCount !== 16'h0 || o_StoreCount !== 16'h0) begin
            n_errors++; $display("FAIL rim_counts got=%0d/%0d exp=0/0", o_LoadCount, o_StoreCount); end
        run_access(LW, 32'h30, 32'h0);
        n_checks++; if (res_lat !== 2 || res_ld !== ref_mem[12]) begin
            n_errors++; $display("FAIL rim_recover got lat=%0d data=%h exp 2/%h", res_lat, res_ld, ref_mem[12]); end
        model_commit(LW, 32'h30, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_loads();
        test_sub_store();
        test_faults();
        test_busy_ignore();
        test_stats();
        test_random();
        test_reset_in_merge();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
